// File: rtl/stack_mem_ctrl_if.sv
// Bus bundle for stack_mem_ctrl.
// Pipeline side: mem_read/mem_write/push/pop requests, alu_result (LDR/STR byte address),
//   val_rm (store data), ready, mem_rdata, sp, stack_err.
// SRAM side: sram_req, sram_we, sram_addr (word address), sram_wdata, sram_rdata, sram_ack.
// master: the controller. slave: the pipeline plus SRAM environment around it.
interface stack_mem_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic        push;
  logic        pop;
  logic [31:0] alu_result;
  logic [31:0] val_rm;
  logic        sram_req;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ack;
  logic        ready;
  logic [31:0] mem_rdata;
  logic [31:0] sp;
  logic        stack_err;

  modport master (
    input  mem_read, mem_write, push, pop, alu_result, val_rm, sram_rdata, sram_ack,
    output sram_req, sram_we, sram_addr, sram_wdata, ready, mem_rdata, sp, stack_err
  );

  modport slave (
    output mem_read, mem_write, push, pop, alu_result, val_rm, sram_rdata, sram_ack,
    input  sram_req, sram_we, sram_addr, sram_wdata, ready, mem_rdata, sp, stack_err
  );
endinterface

// File: rtl/stack_mem_ctrl.sv
// Load/store and hardware-stack controller in front of a single-port word SRAM.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-low reset
//   bus  - stack_mem_ctrl_if.master: pipeline requests/results and the SRAM handshake
// One request is serviced at a time (pop > push > mem_read > mem_write). The request is
// latched in IDLE, the SRAM is held in BUSY until sram_ack, and DONE releases the pipeline.
// Stack overflow/underflow skips the SRAM and goes straight to DONE with stack_err set.
module stack_mem_ctrl #(
  parameter logic [31:0] DATA_BASE  = 32'd1024,
  parameter logic [31:0] STACK_TOP  = 32'h0000_0800,
  parameter logic [31:0] STACK_BASE = 32'h0000_0400
) (
  input  logic             clk,
  input  logic             rst,
  stack_mem_ctrl_if.master bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] OpLdr  = 2'd0;
  localparam logic [1:0] OpStr  = 2'd1;
  localparam logic [1:0] OpPush = 2'd2;
  localparam logic [1:0] OpPop  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] sp_q, sp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  logic        request;
  logic [1:0]  req_op;
  logic [31:0] data_off;
  logic [31:0] sp_dec;

  assign request  = bus.pop | bus.push | bus.mem_read | bus.mem_write;
  assign data_off = bus.alu_result - DATA_BASE;
  assign sp_dec   = sp_q - 32'd4;

  always_comb begin
    req_op = OpStr;
    if (bus.pop) begin
      req_op = OpPop;
    end else if (bus.push) begin
      req_op = OpPush;
    end else if (bus.mem_read) begin
      req_op = OpLdr;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sp_d    = sp_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    case (state_q)
      StIdle: begin
        if (request) begin
          op_d    = req_op;
          state_d = StBusy;
          case (req_op)
            OpPop: begin
              if (sp_q == STACK_TOP) begin
                // Underflow: no access, result forced to zero.
                err_d   = 1'b1;
                rdata_d = 32'd0;
                state_d = StDone;
              end else begin
                addr_d = {2'b00, sp_q[31:2]};
              end
            end
            OpPush: begin
              if (sp_q == STACK_BASE) begin
                err_d   = 1'b1;
                state_d = StDone;
              end else begin
                addr_d  = {2'b00, sp_dec[31:2]};
                wdata_d = bus.val_rm;
              end
            end
            OpLdr: begin
              addr_d = {2'b00, data_off[31:2]};
            end
            default: begin
              addr_d  = {2'b00, data_off[31:2]};
              wdata_d = bus.val_rm;
            end
          endcase
        end
      end
      StBusy: begin
        if (bus.sram_ack) begin
          state_d = StDone;
          case (op_q)
            OpLdr:   rdata_d = bus.sram_rdata;
            OpPop: begin
              rdata_d = bus.sram_rdata;
              sp_d    = sp_q + 32'd4;
            end
            OpPush:  sp_d = sp_dec;
            default: ;
          endcase
        end
      end
      StDone: begin
        // Unconditional: whatever request is present now belongs to the next instruction
        // only once the pipeline has advanced, so it is re-evaluated from IDLE.
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= OpLdr;
      sp_q    <= STACK_TOP;
      rdata_q <= 32'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sp_q    <= sp_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Decoded from state so a reset mid-access drops the request without waiting for a clock.
  assign bus.sram_req   = (state_q == StBusy);
  assign bus.sram_we    = (state_q == StBusy) && ((op_q == OpStr) || (op_q == OpPush));
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.ready      = ((state_q == StIdle) && !request) || (state_q == StDone);
  assign bus.mem_rdata  = rdata_q;
  assign bus.sp         = sp_q;
  assign bus.stack_err  = err_q;

endmodule

// File: doc/stack_mem_ctrl.md
STACK_MEM_CTRL -- requirements
Module: stack_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_BASE, default 32'd1024: byte offset subtracted from LDR/STR addresses.
REQ-002 SHALL have parameter STACK_TOP, default 32'h0000_0800: empty-stack SP value.
REQ-003 SHALL have parameter STACK_BASE, default 32'h0000_0400: lowest legal SP value (full stack).
REQ-004 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports mem_read, mem_write, push, pop, input, 1 each: access requests from the decode/execute pipeline.
REQ-007 SHALL have port alu_result, input, 32: byte address for LDR/STR.
REQ-008 SHALL have port val_rm, input, 32: store data for STR/PUSH.
REQ-009 SHALL have ports sram_req and sram_we, output, 1 each: external memory request and write enable.
REQ-010 SHALL have ports sram_addr and sram_wdata, output, 32 each: word address and write data.
REQ-011 SHALL have ports sram_rdata, input, 32, and sram_ack, input, 1: read data and completion.
REQ-012 SHALL have ports ready, output, 1 (pipeline may advance), and mem_rdata, output, 32 (load/pop result).
REQ-013 SHALL have ports sp, output, 32 (current stack pointer), and stack_err, output, 1 (overflow/underflow pulse).

Function
REQ-014 SHALL implement FSM IDLE, BUSY, DONE.
REQ-015 Request = mem_read|mem_write|push|pop; with multiple asserted, exactly one is serviced, priority pop > push > mem_read > mem_write.
REQ-016 IDLE: ready = !request; on a rising edge with request, latch operation/address/data and go to BUSY, or to DONE directly on a stack error.
REQ-017 Addresses: LDR/STR sram_addr = (alu_result - DATA_BASE) >> 2 (32-bit wrap, low two bits ignored); PUSH sram_addr = (sp - 4) >> 2; POP sram_addr = sp >> 2.
REQ-018 BUSY: sram_req = 1; sram_we = 1 for STR/PUSH, 0 otherwise; sram_addr/sram_wdata held stable; ready = 0; remain in BUSY while sram_ack = 0, with no timeout.
REQ-019 BUSY with sram_ack = 1: capture sram_rdata into mem_rdata for LDR/POP; leave mem_rdata unchanged for STR/PUSH; apply sp -= 4 for PUSH, sp += 4 for POP; go to DONE.
REQ-020 DONE: ready = 1, sram_req = 0; go to IDLE unconditionally, never re-accepting the request present during DONE.
REQ-021 Minimum latency with zero-wait ack: request seen in IDLE, 1 cycle BUSY, 1 cycle DONE; ready low for 2 cycles.
REQ-022 PUSH with sp == STACK_BASE is overflow: no SRAM access, sp unchanged, stack_err = 1 for the single DONE cycle.
REQ-023 POP with sp == STACK_TOP is underflow: no SRAM access, sp unchanged, mem_rdata = 0, stack_err = 1 for the DONE cycle.
REQ-024 stack_err SHALL be 0 in all other cycles; sram_req SHALL be 0 outside BUSY.
REQ-025 Request inputs changing while in BUSY/DONE SHALL be ignored; latched values rule.

Reset
REQ-026 While rst = 0, asynchronously: state = IDLE, sp = STACK_TOP, mem_rdata = 0, stack_err = 0, sram_req = 0, sram_we = 0, sram_addr = 0, sram_wdata = 0.
REQ-027 Reset asserted during BUSY SHALL drop sram_req immediately, discard the access, and leave sp at STACK_TOP; an sram_ack arriving later SHALL be ignored.

Verification
REQ-028 STR alu_result=1032, val_rm=0xDEAD_BEEF, ack after 3 cycles -> sram_addr=2, sram_we=1, sram_wdata=0xDEADBEEF held 3 cycles, ready low 4 cycles.
REQ-029 PUSH val_rm=5 then POP, zero-wait ack -> write at addr 0x1FF, sp=0x7FC; then read at 0x1FF, mem_rdata=5, sp=0x800.
REQ-030 POP right after reset -> no sram_req, stack_err pulse 1 cycle, mem_rdata=0, sp=0x800.
REQ-031 256 PUSHes then one more -> sp=0x400, the 257th gives stack_err=1, no sram_req, sp still 0x400.
REQ-032 mem_read and push both asserted -> PUSH serviced (sram_we=1), LDR dropped.
REQ-033 rst low mid-BUSY, ack 2 cycles later -> sram_req=0 same cycle, sp=0x800, mem_rdata=0, FSM IDLE.
